// File: rtl/id_scoreboard.sv
// Purpose: register-hazard scoreboard for ID; holds an instruction while a source register is pending.
// Latency: ds_ready_go/ds_stall are combinational; counters and sb_busy update at the next posedge.
// Backpressure: ds_ready_go drops on a source or counter-saturation hazard; es_allow_in=0 only defers the fire.
module id_scoreboard #(
  parameter int AW    = 5,
  parameter int NSRC  = 2,
  parameter int CNT_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ds_valid,
  input  logic [NSRC*AW-1:0]   ds_src_addr,
  input  logic [NSRC-1:0]      ds_src_used,
  input  logic [AW-1:0]        ds_dest,
  input  logic                 ds_dest_we,
  input  logic                 es_allow_in,
  input  logic                 ws_we,
  input  logic [AW-1:0]        ws_waddr,
  input  logic                 flush,
  output logic                 ds_ready_go,
  output logic                 ds_stall,
  output logic [(1<<AW)-1:0]   sb_busy,
  output logic                 sb_underflow
);

  localparam int NREG = 1 << AW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [NREG];
  logic             src_hz;
  logic             sat_hz;
  logic             fire;
  logic             inc_en;
  logic             ret_en;

  // Any used, non-zero source whose register still has writes in flight blocks issue.
  always_comb begin
    src_hz = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (ds_src_used[i] && (ds_src_addr[i*AW +: AW] != '0) &&
          (cnt[ds_src_addr[i*AW +: AW]] != '0)) begin
        src_hz = 1'b1;
      end
    end
  end

  // A writer cannot issue while its destination counter would overflow.
  assign sat_hz      = ds_dest_we && (ds_dest != '0) && (cnt[ds_dest] == CNT_MAX);
  assign ds_ready_go = ds_valid && !src_hz && !sat_hz;
  assign ds_stall    = ds_valid && !ds_ready_go;
  assign fire        = ds_valid && ds_ready_go && es_allow_in;
  assign inc_en      = fire && ds_dest_we && (ds_dest != '0);
  assign ret_en      = ws_we && (ws_waddr != '0);

  // Register 0 never matches inc_en/ret_en (both exclude address 0), so its counter stays 0.
  for (genvar r = 0; r < NREG; r++) begin : g_cnt
    localparam logic [AW-1:0] RA = AW'(r);
    logic inc_r;
    logic dec_r;
    assign inc_r = inc_en && (ds_dest == RA);
    assign dec_r = ret_en && (ws_waddr == RA);

    // Per-register in-flight count: flush clears, fire+retire on the same register cancel.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt[r] <= '0;
      end else if (flush) begin
        cnt[r] <= '0;
      end else if (inc_r && !dec_r) begin
        cnt[r] <= cnt[r] + CNT_W'(1);
      end else if (dec_r && !inc_r && (cnt[r] != '0)) begin
        cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end

    assign sb_busy[r] = (cnt[r] != '0);
  end

  // Sticky error flag: a retire hit a register with nothing in flight; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_underflow <= 1'b0;
    end else if (!flush && ret_en && (cnt[ws_waddr] == '0)) begin
      sb_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Purpose: directed self-checking bench for id_scoreboard with default parameters.
// Latency: inputs driven 1ns after posedge, combinational outputs checked 1ns later.
// Backpressure: exercises source, saturation, es_allow_in, flush and async-reset cases.
module tb_id_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        ds_valid;
  logic [9:0]  ds_src_addr;
  logic [1:0]  ds_src_used;
  logic [4:0]  ds_dest;
  logic        ds_dest_we;
  logic        es_allow_in;
  logic        ws_we;
  logic [4:0]  ws_waddr;
  logic        flush;
  logic        ds_ready_go;
  logic        ds_stall;
  logic [31:0] sb_busy;
  logic        sb_underflow;

  int n_checks = 0;
  int n_errors = 0;

  id_scoreboard #(.AW(5), .NSRC(2), .CNT_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ds_valid     (ds_valid),
    .ds_src_addr  (ds_src_addr),
    .ds_src_used  (ds_src_used),
    .ds_dest      (ds_dest),
    .ds_dest_we   (ds_dest_we),
    .es_allow_in  (es_allow_in),
    .ws_we        (ws_we),
    .ws_waddr     (ws_waddr),
    .flush        (flush),
    .ds_ready_go  (ds_ready_go),
    .ds_stall     (ds_stall),
    .sb_busy      (sb_busy),
    .sb_underflow (sb_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] s0, input logic u0, input logic [4:0] s1,
                       input logic u1, input logic [4:0] d, input logic we, input logic allow);
    ds_valid    = 1'b1;
    ds_src_addr = {s1, s0};
    ds_src_used = {u1, u0};
    ds_dest     = d;
    ds_dest_we  = we;
    es_allow_in = allow;
  endtask

  task automatic retire(input logic we, input logic [4:0] a);
    ws_we    = we;
    ws_waddr = a;
  endtask

  task automatic idle();
    ds_valid    = 1'b0;
    ds_src_used = 2'b00;
    ds_dest_we  = 1'b0;
    ws_we       = 1'b0;
    flush       = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    ds_valid    = 1'b0;
    ds_src_addr = '0;
    ds_src_used = '0;
    ds_dest     = '0;
    ds_dest_we  = 1'b0;
    es_allow_in = 1'b0;
    ws_we       = 1'b0;
    ws_waddr    = '0;
    flush       = 1'b0;
    #12;
    chk("rst_busy", sb_busy, 32'h0);
    chk("rst_uf", {31'b0, sb_underflow}, 32'h0);
    ds_valid = 1'b1;
    #1;
    chk("rst_ready", {31'b0, ds_ready_go}, 32'h1);
    chk("rst_stall", {31'b0, ds_stall}, 32'h0);
    ds_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // add.w r4,r1,r2 fires
    issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b1);
    #1 chk("prod_ready", {31'b0, ds_ready_go}, 32'h1);
    cyc();
    chk("prod_busy4", sb_busy, 32'h0000_0010);

    // consumer reads r4, writes r8
    issue(5'd4, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
    #1 chk("cons_stall_a", {31'b0, ds_stall}, 32'h1);
    cyc();
    chk("cons_stall_b", {31'b0, ds_stall}, 32'h1);
    retire(1'b1, 5'd4);
    #1 chk("cons_stall_retcyc", {31'b0, ds_stall}, 32'h1);
    cyc();
    retire(1'b0, 5'd0);
    #1 chk("cons_stall_after", {31'b0, ds_stall}, 32'h0);
    chk("cons_busy_clr", sb_busy, 32'h0);
    cyc();
    chk("cons_busy8", sb_busy, 32'h0000_0100);
    idle();
    retire(1'b1, 5'd8);
    cyc();
    retire(1'b0, 5'd0);
    chk("cons_busy_done", sb_busy, 32'h0);

    // es_allow_in low: ready but no fire
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    #1 chk("noallow_ready", {31'b0, ds_ready_go}, 32'h1);
    cyc();
    chk("noallow_busy", sb_busy, 32'h0);
    // three writers to r7 saturate the counter
    es_allow_in = 1'b1;
    cyc(); cyc(); cyc();
    chk("sat_busy7", sb_busy, 32'h0000_0080);
    chk("sat_stall", {31'b0, ds_stall}, 32'h1);
    retire(1'b1, 5'd7);
    #1 chk("sat_stall_retcyc", {31'b0, ds_stall}, 32'h1);
    cyc();
    retire(1'b0, 5'd0);
    #1 chk("sat_ready_after", {31'b0, ds_ready_go}, 32'h1);
    cyc();
    chk("sat_full_again", {31'b0, ds_stall}, 32'h1);
    idle();
    retire(1'b1, 5'd7);
    cyc(); cyc(); cyc();
    retire(1'b0, 5'd0);
    chk("sat_drain_busy", sb_busy, 32'h0);
    chk("sat_drain_uf", {31'b0, sb_underflow}, 32'h0);

    // fire+retire on r5 with counter 1 -> stays 1
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    cyc();
    retire(1'b1, 5'd5);
    cyc();
    chk("same_busy5", sb_busy, 32'h0000_0020);
    chk("same_uf", {31'b0, sb_underflow}, 32'h0);
    // fire r10 while retiring r5: both apply
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1);
    cyc();
    chk("diff_busy", sb_busy, 32'h0000_0400);

    // r0 sources/dest never stall or count
    retire(1'b0, 5'd0);
    issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1);
    #1 chk("r0_ready", {31'b0, ds_ready_go}, 32'h1);
    cyc();
    chk("r0_busy", sb_busy, 32'h0000_0400);
    idle();
    retire(1'b1, 5'd10);
    cyc();
    // retire r9 with nothing in flight
    retire(1'b1, 5'd9);
    cyc();
    retire(1'b0, 5'd0);
    chk("uf_set", {31'b0, sb_underflow}, 32'h1);
    chk("uf_busy", sb_busy, 32'h0);
    cyc();
    chk("uf_sticky", {31'b0, sb_underflow}, 32'h1);

    // r3=2, r6=1 then flush with a fire to r3 and retire r6
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    cyc(); cyc();
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    cyc();
    chk("pre_flush_busy", sb_busy, 32'h0000_0048);
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    retire(1'b1, 5'd6);
    flush = 1'b1;
    cyc();
    idle();
    chk("flush_busy", sb_busy, 32'h0);
    chk("flush_uf", {31'b0, sb_underflow}, 32'h1);

    // async reset mid-stall (hazard via operand 1)
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
    cyc();
    issue(5'd0, 1'b0, 5'd12, 1'b0, 5'd0, 1'b0, 1'b1);
    #1 chk("unused_src_ready", {31'b0, ds_ready_go}, 32'h1);
    ds_src_used = 2'b10;
    #1 chk("mid_stall", {31'b0, ds_stall}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", sb_busy, 32'h0);
    chk("arst_ready", {31'b0, ds_ready_go}, 32'h1);
    chk("arst_stall", {31'b0, ds_stall}, 32'h0);
    chk("arst_uf", {31'b0, sb_underflow}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Parametrised register-hazard scoreboard for the decode stage of the in-order LoongArch pipeline. It tracks in-flight register writes with one saturating counter per architectural register. It holds the decoded instruction in ID while any source register it needs is still pending, and releases it when the writeback stage retires that register. It drives the ID stage's ready-go term (`ds_ready_go`), replacing the constant-1 ready-go, and sits between ID decode, the ID/EXE handshake and the WB→regfile bus.

## Interface
Parameters:
- `AW`, 5: register address width; tracked registers = 2^AW.
- `NSRC`, 2: number of source operands per instruction.
- `CNT_W`, 2: per-register counter width; max in-flight writes per register = 2^CNT_W − 1.

Ports (clock and reset first):
- `clk`  in  1  — single clock; all state updates on posedge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `ds_valid`  in  1  — ID holds a valid decoded instruction.
- `ds_src_addr`  in  NSRC*AW  — source register addresses; operand i is bits [i*AW +: AW].
- `ds_src_used`  in  NSRC  — operand i is read by this instruction.
- `ds_dest`  in  AW  — destination register.
- `ds_dest_we`  in  1  — instruction writes `ds_dest`.
- `es_allow_in`  in  1  — EXE accepts this cycle.
- `ws_we`  in  1  — WB retires a register write this cycle.
- `ws_waddr`  in  AW  — retiring register.
- `flush`  in  1  — whole back end squashed; clear all tracking.
- `ds_ready_go`  out  1  — ID may issue (no hazard).
- `ds_stall`  out  1  — `ds_valid & ~ds_ready_go`.
- `sb_busy`  out  2^AW  — bit r = counter[r] ≠ 0 (registered state).
- `sb_underflow`  out  1  — sticky error: a retire arrived for a register whose counter was 0.

## Operation
- Register 0 is never tracked:
  - counter[0] stays 0.
  - Sources or destination equal to 0 never cause a hazard or an increment.
- Source hazard on operand i: `ds_src_used[i]` && `addr_i` ≠ 0 && counter[`addr_i`] ≠ 0.
- Saturation hazard: `ds_dest_we` && `ds_dest` ≠ 0 && counter[`ds_dest`] == 2^CNT_W − 1.
- `ds_ready_go` = `ds_valid` && no source hazard && no saturation hazard.
- Issue fire = `ds_valid` && `ds_ready_go` && `es_allow_in`.
- On fire with `ds_dest_we` && `ds_dest` ≠ 0: counter[`ds_dest`] increments by 1.
- Retire (`ws_we` && `ws_waddr` ≠ 0):
  - counter[`ws_waddr`] decrements by 1.
  - If the counter is already 0, it holds at 0 and `sb_underflow` sets.
- Fire and retire on the same register in the same cycle: net counter unchanged; this is not an underflow if the counter was ≥1.
- Fire and retire on different registers in the same cycle: both updates apply.
- No same-cycle bypass: a retire clears a hazard only from the next cycle, matching the posedge-write regfile.
- `flush` takes priority over fire and retire in the same cycle: every counter goes to 0. `sb_underflow` is unaffected.
- `sb_underflow` clears only on reset.

## Timing
- Reset (async assert, released synchronously to `clk` by the system):
  - All counters = 0, `sb_busy` = 0, `sb_underflow` = 0.
  - `ds_ready_go` = `ds_valid` and `ds_stall` = 0.
- `ds_ready_go` and `ds_stall` are combinational from the inputs and registered counters, with zero latency.
- Counters, `sb_busy` and `sb_underflow` change only at posedge (or on async reset).
- Dependent-instruction latency:
  - A producer fires in cycle T.
  - A consumer in ID sees its hazard from T+1.
  - The consumer fires no earlier than the cycle after WB retires the producer.
- `es_allow_in` = 0 with no hazard: `ds_ready_go` = 1, no fire, counters unchanged.
- Reset asserted mid-stall: counters clear immediately, so the stalled instruction (if still valid) is ready at once.

## Test plan
- After reset, issue `add.w r4,r1,r2` (srcs 1,2 used, dest 4, `es_allow_in`=1) → fires; `sb_busy[4]`=1 next cycle; all other bits 0.
- Next cycle, ID holds a consumer with src 4 used → `ds_stall`=1 until `ws_we`=1, `ws_waddr`=4; the stall drops the cycle after the retire edge, not during the retire cycle.
- With CNT_W=2, issue three writes to r7 with no retire → counter 3; a fourth writer to r7 → `ds_stall`=1. One retire of r7 → the writer fires next cycle; counter remains 3.
- In the same cycle, fire a writer to r5 (counter 1) and retire r5 → counter stays 1; `sb_underflow`=0.
- Retire r9 with counter 0 → `sb_underflow`=1 and sticky; counter stays 0. Source r0 or dest r0 → never stalls, `sb_busy[0]`=0.
- Counters r3=2 and r6=1, then assert `flush` together with a fire to r3 → all counters 0 next cycle; `sb_busy`=0.
- Deassert `rst_n` mid-stall → counters clear asynchronously; `ds_ready_go`=`ds_valid`.
